// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU issue sequencer: FSM states, predicate selects
// and condition-code bit positions.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;
  localparam logic [2:0] COND_S      = 3'd5;
  localparam logic [2:0] COND_NS     = 3'd6;
  localparam logic [2:0] COND_P      = 3'd7;

  localparam int CC_SIGN   = 0;
  localparam int CC_CARRY  = 1;
  localparam int CC_ZERO   = 2;
  localparam int CC_PARITY = 3;

endpackage

// File: rtl/alu_seq_cc_cond_eval.sv
// Condition-code predicate: pass is high when cc satisfies the selected condition.
// Purely combinational so branch logic can share it.
module cc_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [2:0] cond,
  output logic       pass
);

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_ALWAYS: pass = 1'b1;
      COND_Z:      pass = cc[CC_ZERO];
      COND_NZ:     pass = !cc[CC_ZERO];
      COND_C:      pass = cc[CC_CARRY];
      COND_NC:     pass = !cc[CC_CARRY];
      COND_S:      pass = cc[CC_SIGN];
      COND_NS:     pass = !cc[CC_SIGN];
      COND_P:      pass = cc[CC_PARITY];
      default:     pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side ALU controller: accepts a request, optionally predicates it on the
// current flags, iterates the op REPEAT+1 times feeding the result back into A.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [3:0]       REQ_OP,
  input  logic [WIDTH-1:0] REQ_A,
  input  logic [WIDTH-1:0] REQ_B,
  input  logic             REQ_SETCC,
  input  logic [2:0]       REQ_COND,
  input  logic [CNT_W-1:0] REQ_REPEAT,
  output logic [WIDTH-1:0] ARGA,
  output logic [WIDTH-1:0] ARGB,
  output logic [3:0]       ALU_OPX,
  output logic             ALU_LD,
  output logic             CCL_LD,
  input  logic [WIDTH-1:0] ALU_R,
  input  logic [3:0]       CCN,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_R,
  output logic [3:0]       RSP_CC,
  output logic             RSP_SKIP
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       op_reg, cc_reg;
  logic [CNT_W-1:0] cnt;
  logic             setcc_reg, skip_reg;
  logic             pass, accept;

  cc_cond_eval u_cond (
    .cc   (CCN),
    .cond (REQ_COND),
    .pass (pass)
  );

  assign REQ_READY = (state == ST_IDLE) && !RESET;
  assign accept    = REQ_VALID && REQ_READY;

  // Operands go straight from the holding registers, so they are stable all ISSUE.
  assign ARGA     = a_reg;
  assign ARGB     = b_reg;
  assign ALU_OPX  = op_reg;
  assign RSP_R    = a_reg;
  assign RSP_CC   = cc_reg;
  assign RSP_SKIP = skip_reg;

  always_comb begin
    state_nxt = state;
    ALU_LD    = 1'b0;
    CCL_LD    = 1'b0;
    RSP_VALID = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = pass ? ST_ISSUE : ST_RESP;
      ST_ISSUE: begin
        ALU_LD    = 1'b1;
        CCL_LD    = setcc_reg;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:  state_nxt = (cnt == '0) ? ST_RESP : ST_ISSUE;
      ST_RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      cc_reg    <= '0;
      cnt       <= '0;
      setcc_reg <= 1'b0;
      skip_reg  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (accept) begin
          a_reg     <= REQ_A;
          b_reg     <= REQ_B;
          op_reg    <= REQ_OP;
          setcc_reg <= REQ_SETCC;
          cnt       <= REQ_REPEAT;
          skip_reg  <= !pass;
          cc_reg    <= CCN;
        end
        ST_WAIT: begin
          a_reg <= ALU_R;
          // Flags are snapshotted on the way into RESP so the response holds steady.
          if (cnt == '0) cc_reg <= CCN;
          else           cnt    <= cnt - CNT_ONE;
        end
        ST_RESP: if (RSP_READY) skip_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a one-cycle registered ALU model
// (OPX 0 = add, OPX 1 = shift-left-1).
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             REQ_VALID = 1'b0;
  logic             REQ_READY;
  logic [3:0]       REQ_OP = '0;
  logic [WIDTH-1:0] REQ_A = '0, REQ_B = '0;
  logic             REQ_SETCC = 1'b0;
  logic [2:0]       REQ_COND = '0;
  logic [CNT_W-1:0] REQ_REPEAT = '0;
  logic [WIDTH-1:0] ARGA, ARGB;
  logic [3:0]       ALU_OPX;
  logic             ALU_LD, CCL_LD;
  logic [WIDTH-1:0] ALU_R = '0;
  logic [3:0]       CCN = '0;
  logic             RSP_VALID;
  logic             RSP_READY = 1'b0;
  logic [WIDTH-1:0] RSP_R;
  logic [3:0]       RSP_CC;
  logic             RSP_SKIP;

  alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_SETCC(REQ_SETCC),
    .REQ_COND(REQ_COND), .REQ_REPEAT(REQ_REPEAT),
    .ARGA(ARGA), .ARGB(ARGB), .ALU_OPX(ALU_OPX), .ALU_LD(ALU_LD), .CCL_LD(CCL_LD),
    .ALU_R(ALU_R), .CCN(CCN),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_R(RSP_R),
    .RSP_CC(RSP_CC), .RSP_SKIP(RSP_SKIP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  cc;
    logic        skip;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, hs_cyc = 0;
  bit   busy = 0, cur_skip = 0, cur_setcc = 0;
  int   cur_rep = 0;
  logic [3:0] m_ccn = '0;

  function automatic logic [16:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 4'd1) return {a, 1'b0};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // {parity, zero, carry, sign}
  function automatic logic [3:0] alu_flags(input logic [16:0] x);
    return {^x[15:0], x[15:0] == 16'h0, x[16], x[15]};
  endfunction

  function automatic logic cond_ok(input logic [3:0] cc, input logic [2:0] cond);
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return cc[2];
      3'd2:    return !cc[2];
      3'd3:    return cc[1];
      3'd4:    return !cc[1];
      3'd5:    return cc[0];
      3'd6:    return !cc[0];
      default: return cc[3];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ALU model: registered result and flags
  logic [16:0] alu_tmp;
  assign alu_tmp = alu_calc(ALU_OPX, ARGA, ARGB);
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ALU_LD) ALU_R <= alu_tmp[15:0];
    if (CCL_LD) CCN <= alu_flags(alu_tmp);
  end

  // Monitor: per-cycle load-pulse pattern and response scoreboard
  initial begin
    int          k;
    bit          exp_ld, in_rsp;
    exp_t        e;
    logic [15:0] h_r;
    logic [3:0]  h_cc;
    logic        h_skip;
    in_rsp = 0;
    forever begin
      @(negedge CLK);
      k = cyc - acc_cyc + 1;
      exp_ld = busy && !cur_skip && (k % 2 == 1) && (k <= 2 * cur_rep + 1);
      chk("alu_ld", 32'(ALU_LD), 32'(exp_ld));
      chk("ccl_ld", 32'(CCL_LD), 32'(exp_ld && cur_setcc));
      if (RSP_VALID) begin
        chk("req_ready_in_resp", 32'(REQ_READY), 32'd0);
        if (!in_rsp) begin
          in_rsp = 1;
          if (q.size() == 0) chk("rsp_unexpected", 32'(RSP_VALID), 32'd0);
          else begin
            e = q.pop_front();
            chk("rsp_lat", k, e.lat);
            chk("rsp_r", 32'(RSP_R), 32'(e.r));
            chk("rsp_cc", 32'(RSP_CC), 32'(e.cc));
            chk("rsp_skip", 32'(RSP_SKIP), 32'(e.skip));
          end
          h_r = RSP_R; h_cc = RSP_CC; h_skip = RSP_SKIP;
        end else begin
          chk("rsp_r_hold", 32'(RSP_R), 32'(h_r));
          chk("rsp_cc_hold", 32'(RSP_CC), 32'(h_cc));
          chk("rsp_skip_hold", 32'(RSP_SKIP), 32'(h_skip));
        end
      end else in_rsp = 0;
    end
  end

  task automatic send_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic setcc, input logic [2:0] cond, input logic [3:0] rep);
    exp_t        e;
    logic [16:0] x;
    logic [15:0] av;
    logic [3:0]  cc;
    bit          rdy;
    int          n;
    REQ_OP = op; REQ_A = a; REQ_B = b; REQ_SETCC = setcc; REQ_COND = cond; REQ_REPEAT = rep;
    REQ_VALID = 1'b1;
    rdy = REQ_READY;
    n = 0;
    while (!rdy && n < 50) begin @(negedge CLK); rdy = REQ_READY; n++; end
    if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    acc_cyc = cyc;
    e.skip = !cond_ok(m_ccn, cond);
    av = a; cc = m_ccn;
    if (!e.skip)
      for (int i = 0; i <= int'(rep); i++) begin
        x = alu_calc(op, av, b);
        av = x[15:0];
        if (setcc) cc = alu_flags(x);
      end
    m_ccn = cc;
    e.r = av; e.cc = cc;
    e.lat = e.skip ? 1 : 3 + 2 * int'(rep);
    q.push_back(e);
    cur_skip = e.skip; cur_setcc = setcc; cur_rep = int'(rep); busy = 1;
  endtask

  task automatic get_rsp(input int hold);
    int n;
    n = 0;
    while (!RSP_VALID && n < 100) begin @(negedge CLK); n++; end
    if (!RSP_VALID) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      busy = 0; q.delete();
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge CLK);
      #1 RSP_READY = 1'b1;
    end
    @(posedge CLK); #1;
    hs_cyc = cyc; busy = 0; RSP_READY = 1'b0;
    @(negedge CLK);
    chk("rsp_clear", 32'(RSP_VALID), 32'd0);
    chk("ready_after_hs", 32'(REQ_READY), 32'd1);
  endtask

  task automatic do_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic setcc, input logic [2:0] cond, input logic [3:0] rep, input int hold);
    RSP_READY = (hold == 0);
    send_req(op, a, b, setcc, cond, rep);
    get_rsp(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_save;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_arga", 32'(ARGA), 32'd0);
    chk("rst_rsp_r", 32'(RSP_R), 32'd0);
    chk("rst_rsp_skip", 32'(RSP_SKIP), 32'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("ready_after_rst", 32'(REQ_READY), 32'd1);

    do_req(4'd0, 16'h0003, 16'h0004, 1'b1, COND_ALWAYS, 4'd0, 0);   // single add
    do_req(4'd1, 16'h0001, 16'h0000, 1'b1, COND_ALWAYS, 4'd3, 0);   // iterated shift
    do_req(4'd0, 16'h1234, 16'h0001, 1'b1, COND_Z, 4'd0, 0);        // Z=0 -> skip
    do_req(4'd0, 16'h0003, 16'h0004, 1'b1, COND_ALWAYS, 4'd0, 5);   // backpressure
    hs_save = hs_cyc;
    do_req(4'd0, 16'hFFFF, 16'h0001, 1'b0, COND_ALWAYS, 4'd0, 0);   // flag gating
    chk("b2b_accept", acc_cyc, hs_save + 1);
    do_req(4'd0, 16'hFFFF, 16'h0001, 1'b1, COND_ALWAYS, 4'd0, 1);   // sets Z and C
    do_req(4'd0, 16'h0005, 16'h0005, 1'b1, COND_Z, 4'd0, 0);
    do_req(4'd0, 16'h0009, 16'h0009, 1'b0, COND_NC, 4'd1, 0);
    do_req(4'd1, 16'h4321, 16'h0000, 1'b1, COND_C, 4'd0, 2);        // C=0 -> skip
    do_req(4'd0, 16'h0000, 16'h0001, 1'b1, COND_ALWAYS, 4'd15, 0);  // max repeat
    for (int i = 0; i < 8; i++)
      do_req(4'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

    // Reset in the second WAIT of a REPEAT=5 request abandons it
    RSP_READY = 1'b1;
    send_req(4'd1, 16'h0001, 16'h0000, 1'b0, COND_ALWAYS, 4'd5);
    repeat (3) @(posedge CLK);
    #1;
    busy = 0; q.delete(); RESET = 1'b1;
    @(negedge CLK);
    chk("req_ready_in_rst", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("ready_post_rst", 32'(REQ_READY), 32'd1);
    chk("rsp_valid_post_rst", 32'(RSP_VALID), 32'd0);
    repeat (20) @(negedge CLK);
    do_req(4'd0, 16'h0010, 16'h0020, 1'b1, COND_ALWAYS, 4'd2, 0);   // recovery

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue-side controller for aluBlock; it is the producer of ARGA/ARGB/ALU_OPX/ALU_LD/CCL_LD and the consumer of ALU_R/CCN.
- Accepts ALU requests from decode over a valid/ready handshake.
- Optionally predicates each request on the current condition codes.
- Iterates an operation N+1 times, feeding the result back into A (e.g. multi-bit shift built from single-bit ALU ops).
- Returns the result and flags over a valid/ready response handshake.

Parameters:
WIDTH, 16, datapath width; matches ALU ARGA/ARGB/ALU_R.
CNT_W, 4, width of the repeat count; maximum iterations 2^CNT_W.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  synchronous, active-high reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  block can accept a request.
REQ_OP  input  4  ALU opcode, passed to ALU_OPX.
REQ_A  input  WIDTH  operand A.
REQ_B  input  WIDTH  operand B.
REQ_SETCC  input  1  update flags (CCL_LD) on each issue.
REQ_COND  input  3  predicate select.
REQ_REPEAT  input  CNT_W  extra iterations; 0 means a single issue.
ARGA  output  WIDTH  to ALU.
ARGB  output  WIDTH  to ALU.
ALU_OPX  output  4  to ALU.
ALU_LD  output  1  one-cycle load pulse to ALU result register.
CCL_LD  output  1  one-cycle load pulse to ALU flag register.
ALU_R  input  WIDTH  registered ALU result.
CCN  input  4  registered flags: [0] sign, [1] carry, [2] zero, [3] parity.
RSP_VALID  output  1  response present.
RSP_READY  input  1  consumer accepts the response.
RSP_R  output  WIDTH  final result; holds A_REG when skipped.
RSP_CC  output  4  CCN sampled at the response.
RSP_SKIP  output  1  predicate was false; the ALU was not touched.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; A_REG, B_REG, OP_REG, CNT, SETCC_REG and all outputs go to 0.
  - REQ_READY is forced 0 while RESET is high.
  - Reset mid-operation abandons the operation: no ALU_LD after reset, and no response is produced.
- States: IDLE, ISSUE, WAIT, RESP. REQ_READY = (state==IDLE) and not RESET.
- IDLE:
  - Acceptance occurs on REQ_VALID & REQ_READY at edge T.
  - At acceptance, capture A/B/OP/SETCC/REPEAT and evaluate the predicate against the current CCN.
  - Predicate true -> ISSUE. Predicate false -> RESP with RSP_SKIP=1.
- Predicate encoding (REQ_COND):
  - 0 always
  - 1 Z=1
  - 2 Z=0
  - 3 C=1
  - 4 C=0
  - 5 S=1
  - 6 S=0
  - 7 P=1
- ISSUE (cycle T+1):
  - ALU_LD=1; CCL_LD=SETCC_REG.
  - ARGA=A_REG, ARGB=B_REG, ALU_OPX=OP_REG, all registered and stable for the whole ISSUE cycle.
  - Next state: WAIT.
- WAIT (ALU_R valid):
  - A_REG <= ALU_R.
  - If CNT==0 -> RESP; else CNT <= CNT-1 -> ISSUE.
- Latency:
  - RSP_VALID first high in cycle T+3+2*REPEAT.
  - Skipped request: RSP_VALID high in cycle T+1.
- RESP:
  - RSP_VALID=1; RSP_R=A_REG; RSP_CC=CCN; RSP_SKIP as decided at acceptance.
  - All response outputs stay stable until RSP_READY.
  - On RSP_VALID & RSP_READY -> IDLE, clearing RSP_VALID and RSP_SKIP.
  - A new request can be accepted the cycle after the handshake; there is no request/response overlap.
- ALU_LD and CCL_LD are never high outside ISSUE. Exactly REPEAT+1 ALU_LD pulses occur per non-skipped request.
- RSP_READY held high in advance is legal; the response completes in its first RESP cycle.
- REQ_REPEAT = 2^CNT_W-1 gives 2^CNT_W issues with no wrap; CNT is never decremented below 0.
- ARGB and ALU_OPX stay constant across iterations.

Decomposition:
- Package alu_seq_pkg holds:
  - the state encoding;
  - COND_* predicate constants;
  - CC bit indices (CC_SIGN=0, CC_CARRY=1, CC_ZERO=2, CC_PARITY=3).
- One natural sub-module, cc_cond_eval: combinational CCN x REQ_COND -> pass. It is reused later by branch logic.

Test Plan:
The bench ALU model has a one-cycle registered result and flags; OPX 0 = add, OPX 1 = shift-left-1.
1. Single add: A=0x0003, B=0x0004, COND=0, REPEAT=0, SETCC=1, accept at T.
   -> ALU_LD and CCL_LD high only at T+1; RSP_VALID at T+3 with RSP_R=0x0007, RSP_CC zero bit=0, RSP_SKIP=0.
2. Iterated shift: OP=1, A=0x0001, REPEAT=3.
   -> 4 ALU_LD pulses spaced 2 cycles apart; RSP_R=0x0010 at T+9.
3. Predicate false: CCN zero bit=0, COND=1.
   -> No ALU_LD/CCL_LD; RSP_VALID at T+1 with RSP_SKIP=1 and RSP_R=REQ_A.
4. Backpressure: RSP_READY low for 5 cycles in scenario 1.
   -> RSP_* stable and REQ_READY=0 throughout; a new request is accepted the cycle after the handshake.
5. Flag gating: SETCC=0 on a 0xFFFF+0x0001 add.
   -> CCL_LD never high; RSP_CC equals the pre-request CCN; RSP_R=0x0000.
6. Reset during WAIT of a REPEAT=5 request.
   -> No further ALU_LD; REQ_READY=0 during RESET, 1 in the first cycle after; no RSP_VALID.
